// File: rtl/zmips_pkg.sv
// Shared writeback definitions: special register numbers,
// the writability rule and the queued result entry.
package zmips_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_PC_LIVE  = 5'd31;
  localparam logic [ADDR_W-1:0] REG_PC_SAVED = 5'd30;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
    return (addr != REG_PC_LIVE) && (addr != REG_PC_SAVED);
  endfunction

endpackage

// File: rtl/zmips_wb_fifo.sv
// In-order result buffer: up to two pushes and one pop per cycle,
// with every slot exposed for the forwarding search.
module zmips_wb_fifo
  import zmips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  wb_entry_t     push_a_i,
  input  wb_entry_t     push_b_i,
  input  logic          pop_i,
  output wb_entry_t     ent_o [DEPTH],
  output logic [PW-1:0] head_o,
  output logic [CW-1:0] count_o
);

  wb_entry_t     ent_q [DEPTH];
  wb_entry_t     ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    if (pop_i) begin
      ent_d[head_q].valid = 1'b0;
      head_d = head_q + PW'(1);
    end
    // a lone push always lands at tail, keeping the buffer compact
    if (push_a_i.valid)
      ent_d[tail_q] = push_a_i;
    if (push_b_i.valid)
      ent_d[tail_q + PW'(push_a_i.valid)] = push_b_i;
    tail_d  = tail_q + PW'(push_a_i.valid)
                     + PW'(push_b_i.valid);
    count_d = count_q + CW'(push_a_i.valid)
                      + CW'(push_b_i.valid)
                      - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign ent_o   = ent_q;
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/zmips_wb_queue.sv
// Writeback arbiter: merges ALU and load results into one
// register-file write port and answers forwarding queries.
module zmips_wb_queue
  import zmips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          wr,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] q_addr,
  output logic          q_hit,
  output logic [DW-1:0] q_data,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     ent [DEPTH];
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  wb_entry_t     push_a, push_b;
  logic          pop;

  logic          wr_q, wr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  // load results get the last free slot
  assign mem_ready = count < CW'(DEPTH);
  assign alu_ready = (count <= CW'(DEPTH - 2))
                  || (count == CW'(DEPTH - 1) && !mem_valid);

  always_comb begin
    push_a = '{valid: mem_valid && mem_ready && is_writable(mem_addr),
               addr: mem_addr, data: mem_data};
    push_b = '{valid: alu_valid && alu_ready && is_writable(alu_addr),
               addr: alu_addr, data: alu_data};
  end

  assign pop = count != '0;

  zmips_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_a_i (push_a),
    .push_b_i (push_b),
    .pop_i    (pop),
    .ent_o    (ent),
    .head_o   (head),
    .count_o  (count)
  );

  always_comb begin
    wr_d      = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_addr_d = ent[head].addr;
      wr_data_d = ent[head].data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr      = wr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign empty   = (count == '0) && !wr_q;

  // walk oldest to youngest so the youngest match overrides
  always_comb begin
    logic [PW-1:0] idx;
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    if (wr_q && wr_addr_q == q_addr) begin
      q_hit  = 1'b1;
      q_data = wr_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent[idx].valid && ent[idx].addr == q_addr) begin
        q_hit  = 1'b1;
        q_data = ent[idx].data;
      end
    end
    if (!is_writable(q_addr)) begin
      q_hit  = 1'b0;
      q_data = '0;
    end
  end

endmodule

// File: tb/tb_zmips_wb_queue.sv
// Scoreboard bench for the writeback queue: stimulus pushes
// expected writes, a negedge monitor pops and compares them.
module tb_zmips_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr, wr_addr, q_addr;
  logic [31:0] alu_data, mem_data, wr_data, q_data;
  logic        wr, q_hit, empty;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cnt_m    = 0;
  logic [36:0] sb [$];

  always #5 clk = ~clk;

  zmips_wb_queue dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .wr        (wr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .q_addr    (q_addr),
    .q_hit     (q_hit),
    .q_data    (q_data),
    .empty     (empty)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // one cycle of stimulus; the model decides acceptance from its own count
  task automatic drive(input bit mv, input logic [4:0] ma,
                       input logic [31:0] md,
                       input bit av, input logic [4:0] aa,
                       input logic [31:0] ad);
    int  free;
    bit  emr, ear;
    int  pushes;
    @(posedge clk); #1;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    #1;
    free = 4 - cnt_m;
    emr  = free >= 1;
    ear  = (free >= 2) || (free == 1 && !mv);
    check("mem_ready", {31'b0, mem_ready}, {31'b0, emr});
    check("alu_ready", {31'b0, alu_ready}, {31'b0, ear});
    pushes = 0;
    if (mv && emr && ma[4:1] != 4'hF) begin
      sb.push_back({ma, md});
      pushes++;
    end
    if (av && ear && aa[4:1] != 4'hF) begin
      sb.push_back({aa, ad});
      pushes++;
    end
    cnt_m = cnt_m + pushes - ((cnt_m > 0) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && wr) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL wr_spurious: got wr to r%0d = %h, expected none",
                 wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        check("wr_addr", {27'b0, wr_addr}, {27'b0, e[36:32]});
        check("wr_data", wr_data, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    q_addr = 5'd3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr", {31'b0, wr}, 32'd0);
    check("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_q_hit", {31'b0, q_hit}, 32'd0);

    // single ALU write and its latency
    drive(0, 5'd0, 32'd0, 1, 5'd3, 32'h11111111);
    idle(1);
    @(negedge clk);
    check("lat_wr_low", {31'b0, wr}, 32'd0);
    check("lat_q_hit", {31'b0, q_hit}, 32'd1);
    check("lat_q_data", q_data, 32'h11111111);
    idle(1);
    @(negedge clk);
    check("lat_wr_high", {31'b0, wr}, 32'd1);
    idle(1);
    @(negedge clk);
    check("lat_empty", {31'b0, empty}, 32'd1);

    // both producers in one cycle: mem first
    drive(1, 5'd5, 32'hAAAA0000, 1, 5'd6, 32'h0000BBBB);
    idle(4);

    // fill: two per cycle until memory takes the last slot
    drive(1, 5'd1, 32'h101, 1, 5'd2, 32'h102);
    drive(1, 5'd3, 32'h103, 1, 5'd4, 32'h104);
    drive(1, 5'd8, 32'h108, 1, 5'd9, 32'h109);
    check("fill_alu_ready", {31'b0, alu_ready}, 32'd0);
    check("fill_mem_ready", {31'b0, mem_ready}, 32'd1);
    for (int k = 0; k < 20; k++)
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom);
    idle(8);

    // unwritable destinations
    q_addr = 5'd30;
    drive(0, 5'd0, 32'd0, 1, 5'd30, 32'hDEADBEEF);
    drive(0, 5'd0, 32'd0, 1, 5'd31, 32'hDEADBEEF);
    idle(3);
    @(negedge clk);
    check("pc_empty", {31'b0, empty}, 32'd1);
    check("pc_q_hit", {31'b0, q_hit}, 32'd0);

    // youngest pending write is forwarded
    q_addr = 5'd7;
    drive(0, 5'd0, 32'd0, 1, 5'd7, 32'd1);
    drive(0, 5'd0, 32'd0, 1, 5'd7, 32'd2);
    idle(1);
    @(negedge clk);
    check("fwd_q_hit", {31'b0, q_hit}, 32'd1);
    check("fwd_q_data", q_data, 32'd2);
    idle(3);
    @(negedge clk);
    check("fwd_drained_hit", {31'b0, q_hit}, 32'd0);

    // reset with entries pending
    q_addr = 5'd9;
    drive(1, 5'd8, 32'h208, 1, 5'd9, 32'h209);
    drive(1, 5'd10, 32'h20A, 1, 5'd11, 32'h20B);
    @(posedge clk); #1;
    mem_valid = 0; alu_valid = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    cnt_m = 0;
    @(negedge clk);
    check("mrst_wr", {31'b0, wr}, 32'd0);
    check("mrst_empty", {31'b0, empty}, 32'd1);
    check("mrst_alu_ready", {31'b0, alu_ready}, 32'd1);
    check("mrst_mem_ready", {31'b0, mem_ready}, 32'd1);
    check("mrst_q_hit", {31'b0, q_hit}, 32'd0);
    idle(4);

    check("sb_drained", sb.size(), 32'd0);
    check("final_empty", {31'b0, empty}, 32'd1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
